ball_position_tracker: RTL and testbench
========================================

BALL_POSITION_TRACKER -- requirements
Module: ball_position_tracker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- GRID_W, 32, maze columns (x range 0..GRID_W-1).
- GRID_H, 24, maze rows (y range 0..GRID_H-1).
- START_X, 1, x start cell.
- START_Y, 1, y start cell.
- XW = $clog2(GRID_W), YW = $clog2(GRID_H): derived coordinate widths.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high reset.
- move_pulses, in, 4, one-cycle tick requests: [0] +x, [1] -x, [2] +y, [3] -y.
- restart, in, 1, synchronous return to start; clears win.
- cell_req, out, 1, maze-cell lookup request.
- cell_addr, out, YW+XW, target cell {y,x}.
- cell_ack, in, 1, lookup complete; cell_type valid this cycle.
- cell_type, in, 2, cell code: 0 OPEN, 1 WALL, 2 GOAL, 3 HOLE.
- pos_x, out, XW, current ball column.
- pos_y, out, YW, current ball row.
- moved, out, 1, one-cycle pulse when the position advanced.
- blocked, out, 1, one-cycle pulse when a move hit a WALL.
- fell, out, 1, one-cycle pulse when the ball entered a HOLE.
- win, out, 1, sticky flag; GOAL reached.
- busy, out, 1, high when the FSM is not IDLE.

Function
REQ-003 Each axis SHALL hold one pending request: a valid bit plus a direction bit.
REQ-004 A pulse on bit 0 XOR bit 1 SHALL set pend_x at the next edge with the matching direction; pulses on both bits in the same cycle SHALL be ignored. The y axis SHALL behave the same using bits 2 and 3.
REQ-005 A new pulse on an axis already pending SHALL overwrite that axis's direction. Requests SHALL NOT queue.
REQ-006 The FSM SHALL have three states: IDLE, REQ and APPLY.
REQ-007 In IDLE with any pending request, x SHALL take priority over y. Servicing SHALL clear that axis's pending bit, unless a new pulse on the same axis arrives in the same cycle, in which case the new pulse sets it.
REQ-008 If the target cell is outside the grid (x=0 moving -x, x=GRID_W-1 moving +x, and likewise for y), the request SHALL be dropped, blocked SHALL pulse, no lookup SHALL be issued, and the FSM SHALL stay in IDLE.
REQ-009 Otherwise the FSM SHALL go to REQ. cell_req SHALL be 1 in REQ, and cell_addr SHALL be registered and stable until ack.
REQ-010 Latency: for a pulse in cycle N with the FSM idle, cell_req SHALL be first high in cycle N+2.
REQ-011 In REQ, cell_ack SHALL be sampled with cell_type. The FSM SHALL go to APPLY next, and cell_req SHALL be low from that cycle. The minimum REQ dwell SHALL be 1 cycle, with no upper bound.
REQ-012 cell_ack SHALL be ignored in any state other than REQ.
REQ-013 APPLY SHALL last one cycle, then return to IDLE, with actions by cell type:
- OPEN: pos <= target; moved=1.
- WALL: pos unchanged; blocked=1.
- GOAL: pos <= target; moved=1; win <= 1.
- HOLE: pos <= (START_X, START_Y); fell=1; both pending bits cleared.
REQ-014 While win=1, pulses SHALL NOT be captured and the FSM SHALL remain in IDLE. pos SHALL hold.
REQ-015 restart SHALL act in any state: pos <= start, win/pending cleared, FSM <= IDLE, cell_req <= 0. An in-flight lookup SHALL be abandoned and its late ack ignored.
REQ-016 If restart and move_pulses occur in the same cycle, restart SHALL win and the pulses SHALL be discarded.
REQ-017 moved, blocked and fell SHALL be mutually exclusive. Each SHALL be high exactly one cycle per event.

Reset
REQ-018 Reset SHALL set:
- pos_x=START_X, pos_y=START_Y;
- win=0, moved=0, blocked=0, fell=0;
- cell_req=0, cell_addr=0, busy=0;
- pending cleared, FSM=IDLE.
REQ-019 Reset SHALL take priority over restart and all other inputs, including mid-lookup.

Structure
REQ-020 A shared package SHALL hold the cell_type codes, the move_pulses bit indices, and the FSM state enum. The upstream tick generator and the maze ROM controller SHALL use the same package.
REQ-021 The per-axis pending logic SHALL be one sub-module, axis_pending_latch, instantiated twice (x and y).

Verification
REQ-022 OPEN move: from start (1,1), +x pulse with ack after 3 cycles and cell_type=0 -> cell_addr={1,2}; pos=(2,1); moved high one cycle; busy high from N+2 until APPLY.
REQ-023 WALL: -y pulse with cell_type=1 -> pos stays (1,1); blocked=1 for one cycle; no moved.
REQ-024 Edge: pos x=0, -x pulse -> cell_req never asserted; blocked=1; pos unchanged.
REQ-025 HOLE: ball at (5,5), +y with cell_type=3 while pend_x is set -> pos=(1,1); fell=1; pend_x cleared, so no further cell_req.
REQ-026 Simultaneous +x/+y pulses -> x serviced first, then y. Further +x pulses during the x lookup collapse into one extra request.
REQ-027 Mid-lookup: restart during REQ then ack 2 cycles later -> cell_req drops the next cycle; ack ignored; pos=(1,1). Separately, GOAL sets win and later pulses produce no cell_req.

Source files
------------

// File: rtl/ball_position_tracker_pkg.sv
// Shared definitions for the ball tracker, the tick generator and the maze ROM controller.
package ball_position_tracker_pkg;

    // Maze cell codes returned by the ROM controller
    typedef logic [1:0] cell_t;
    localparam cell_t CELL_OPEN = 2'd0;
    localparam cell_t CELL_WALL = 2'd1;
    localparam cell_t CELL_GOAL = 2'd2;
    localparam cell_t CELL_HOLE = 2'd3;

    // Bit positions inside move_pulses
    localparam int unsigned MV_W     = 4;
    localparam int unsigned MV_POS_X = 0;
    localparam int unsigned MV_NEG_X = 1;
    localparam int unsigned MV_POS_Y = 2;
    localparam int unsigned MV_NEG_Y = 3;

    // Tracker FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_REQ   = 2'd1;
    localparam state_t ST_APPLY = 2'd2;

endpackage

// File: rtl/ball_position_tracker_axis_pending_latch.sv
// One-deep pending move request for a single axis: valid bit plus direction (1 = negative).
module axis_pending_latch
    import ball_position_tracker_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_capture_en,
    input  logic i_service,
    input  logic i_flush,
    output logic o_valid,
    output logic o_dir
);

    logic r_valid;
    logic r_dir;
    logic w_capture;

    // Opposite pulses in the same cycle cancel out
    assign w_capture = i_capture_en & (i_inc ^ i_dec);

    // Flush beats a new pulse, a new pulse beats servicing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_dir   <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_dir   <= i_dec;
        end else if (i_service) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_dir   = r_dir;

endmodule

// File: rtl/ball_position_tracker.sv
// Tracks the ball cell in a maze: captures move ticks, looks up the target cell, applies the result.
module ball_position_tracker
    import ball_position_tracker_pkg::*;
#(
    parameter  int unsigned GRID_W  = 32,
    parameter  int unsigned GRID_H  = 24,
    parameter  int unsigned START_X = 1,
    parameter  int unsigned START_Y = 1,
    localparam int unsigned XW      = $clog2(GRID_W),
    localparam int unsigned YW      = $clog2(GRID_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MV_W-1:0]    move_pulses,
    input  logic               restart,
    output logic               cell_req,
    output logic [YW+XW-1:0]   cell_addr,
    input  logic               cell_ack,
    input  logic [1:0]         cell_type,
    output logic [XW-1:0]      pos_x,
    output logic [YW-1:0]      pos_y,
    output logic               moved,
    output logic               blocked,
    output logic               fell,
    output logic               win,
    output logic               busy
);

    state_t          r_state;
    logic [XW-1:0]   r_pos_x;
    logic [YW-1:0]   r_pos_y;
    logic [XW-1:0]   r_tgt_x;
    logic [YW-1:0]   r_tgt_y;
    cell_t           r_type;
    logic            r_win;
    logic            r_moved;
    logic            r_blocked;
    logic            r_fell;
    logic            r_cell_req;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [XW-1:0]   w_pos_x_nxt;
    logic [YW-1:0]   w_pos_y_nxt;
    logic [XW-1:0]   w_tgt_x_nxt;
    logic [YW-1:0]   w_tgt_y_nxt;
    cell_t           w_type_nxt;
    logic            w_win_nxt;
    logic            w_moved_nxt;
    logic            w_blocked_nxt;
    logic            w_fell_nxt;
    logic            w_service_x;
    logic            w_service_y;
    logic            w_flush;
    logic            w_capture_en;
    logic            w_pend_x_v;
    logic            w_pend_x_dir;
    logic            w_pend_y_v;
    logic            w_pend_y_dir;

    // Once the goal is reached, ticks are ignored until restart
    assign w_capture_en = ~r_win;

    axis_pending_latch u_pend_x (
        .clk          (clk),
        .reset        (reset),
        .i_inc        (move_pulses[MV_POS_X]),
        .i_dec        (move_pulses[MV_NEG_X]),
        .i_capture_en (w_capture_en),
        .i_service    (w_service_x),
        .i_flush      (w_flush),
        .o_valid      (w_pend_x_v),
        .o_dir        (w_pend_x_dir)
    );

    axis_pending_latch u_pend_y (
        .clk          (clk),
        .reset        (reset),
        .i_inc        (move_pulses[MV_POS_Y]),
        .i_dec        (move_pulses[MV_NEG_Y]),
        .i_capture_en (w_capture_en),
        .i_service    (w_service_y),
        .i_flush      (w_flush),
        .o_valid      (w_pend_y_v),
        .o_dir        (w_pend_y_dir)
    );

    // Next-state and action logic; restart overrides everything at the end
    always_comb begin
        w_state_nxt   = r_state;
        w_pos_x_nxt   = r_pos_x;
        w_pos_y_nxt   = r_pos_y;
        w_tgt_x_nxt   = r_tgt_x;
        w_tgt_y_nxt   = r_tgt_y;
        w_type_nxt    = r_type;
        w_win_nxt     = r_win;
        w_moved_nxt   = 1'b0;
        w_blocked_nxt = 1'b0;
        w_fell_nxt    = 1'b0;
        w_service_x   = 1'b0;
        w_service_y   = 1'b0;
        w_flush       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!r_win && (w_pend_x_v || w_pend_y_v)) begin
                    if (w_pend_x_v) begin
                        w_service_x = 1'b1;
                        if (w_pend_x_dir ? (r_pos_x == '0) : (r_pos_x == XW'(GRID_W - 1))) begin
                            w_blocked_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_REQ;
                            w_tgt_x_nxt = w_pend_x_dir ? r_pos_x - XW'(1) : r_pos_x + XW'(1);
                            w_tgt_y_nxt = r_pos_y;
                        end
                    end else begin
                        w_service_y = 1'b1;
                        if (w_pend_y_dir ? (r_pos_y == '0) : (r_pos_y == YW'(GRID_H - 1))) begin
                            w_blocked_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_REQ;
                            w_tgt_x_nxt = r_pos_x;
                            w_tgt_y_nxt = w_pend_y_dir ? r_pos_y - YW'(1) : r_pos_y + YW'(1);
                        end
                    end
                end
            end
            ST_REQ: begin
                if (cell_ack) begin
                    w_state_nxt = ST_APPLY;
                    w_type_nxt  = cell_type;
                end
            end
            ST_APPLY: begin
                w_state_nxt = ST_IDLE;
                case (r_type)
                    CELL_OPEN: begin
                        w_pos_x_nxt = r_tgt_x;
                        w_pos_y_nxt = r_tgt_y;
                        w_moved_nxt = 1'b1;
                    end
                    CELL_WALL: begin
                        w_blocked_nxt = 1'b1;
                    end
                    CELL_GOAL: begin
                        w_pos_x_nxt = r_tgt_x;
                        w_pos_y_nxt = r_tgt_y;
                        w_moved_nxt = 1'b1;
                        w_win_nxt   = 1'b1;
                    end
                    CELL_HOLE: begin
                        w_pos_x_nxt = XW'(START_X);
                        w_pos_y_nxt = YW'(START_Y);
                        w_fell_nxt  = 1'b1;
                        w_flush     = 1'b1;
                    end
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (restart) begin
            w_state_nxt   = ST_IDLE;
            w_pos_x_nxt   = XW'(START_X);
            w_pos_y_nxt   = YW'(START_Y);
            w_win_nxt     = 1'b0;
            w_moved_nxt   = 1'b0;
            w_blocked_nxt = 1'b0;
            w_fell_nxt    = 1'b0;
            w_service_x   = 1'b0;
            w_service_y   = 1'b0;
            w_flush       = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pos_x    <= XW'(START_X);
            r_pos_y    <= YW'(START_Y);
            r_tgt_x    <= '0;
            r_tgt_y    <= '0;
            r_type     <= CELL_OPEN;
            r_win      <= 1'b0;
            r_moved    <= 1'b0;
            r_blocked  <= 1'b0;
            r_fell     <= 1'b0;
            r_cell_req <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos_x    <= w_pos_x_nxt;
            r_pos_y    <= w_pos_y_nxt;
            r_tgt_x    <= w_tgt_x_nxt;
            r_tgt_y    <= w_tgt_y_nxt;
            r_type     <= w_type_nxt;
            r_win      <= w_win_nxt;
            r_moved    <= w_moved_nxt;
            r_blocked  <= w_blocked_nxt;
            r_fell     <= w_fell_nxt;
            r_cell_req <= (w_state_nxt == ST_REQ);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign cell_req  = r_cell_req;
    assign cell_addr = {r_tgt_y, r_tgt_x};
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign moved     = r_moved;
    assign blocked   = r_blocked;
    assign fell      = r_fell;
    assign win       = r_win;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ball_position_tracker.sv
// Self-checking bench for ball_position_tracker: directed scenarios plus a randomized run against a reference model.
module tb_ball_position_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] move_pulses;
    logic       restart;
    logic       cell_req;
    logic [9:0] cell_addr;
    logic       cell_ack;
    logic [1:0] cell_type;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic       moved;
    logic       blocked;
    logic       fell;
    logic       win;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ball_position_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .move_pulses (move_pulses),
        .restart     (restart),
        .cell_req    (cell_req),
        .cell_addr   (cell_addr),
        .cell_ack    (cell_ack),
        .cell_type   (cell_type),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .moved       (moved),
        .blocked     (blocked),
        .fell        (fell),
        .win         (win),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (cell_req !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (cell_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_timeout cell_req=%b want 1", name, cell_req);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Pulse one direction, wait for the lookup, answer it; returns in the cycle after APPLY
    task automatic do_move(input int idx, input logic [1:0] t, input string name);
        move_pulses = 4'(1 << idx);
        tick();
        move_pulses = 4'h0;
        wait_req(name);
        cell_type = t;
        cell_ack  = 1'b1;
        tick();
        cell_ack  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; restart = 1'b1; move_pulses = 4'hF; cell_ack = 1'b1; cell_type = 2'd2;
        tick(); tick();
        checks++;
        if (pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL reset_pos got (%0d,%0d) want (1,1)", pos_x, pos_y);
        end
        checks++;
        if ({win, moved, blocked, fell, cell_req, busy} !== 6'b0 || cell_addr !== 10'd0) begin
            errors++; $display("FAIL reset_outputs got flags=%b addr=%h want 0/0",
                               {win, moved, blocked, fell, cell_req, busy}, cell_addr);
        end
        reset = 1'b0; restart = 1'b0; move_pulses = 4'h0; cell_ack = 1'b0;
        tick(); tick();
        checks++;
        if (cell_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_pending got req=%b busy=%b want 0 0", cell_req, busy);
        end
    endtask

    task automatic test_open_move();
        do_restart();
        move_pulses = 4'b0001;
        tick();
        move_pulses = 4'h0;
        checks++;
        if (cell_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL open_n1 got req=%b busy=%b want 0 0", cell_req, busy);
        end
        tick();
        checks++;
        if (cell_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL open_n2 got req=%b busy=%b want 1 1", cell_req, busy);
        end
        checks++;
        if (cell_addr !== 10'h022) begin
            errors++; $display("FAIL open_addr got %h want 022", cell_addr);
        end
        tick(); tick();
        checks++;
        if (cell_req !== 1'b1 || cell_addr !== 10'h022) begin
            errors++; $display("FAIL open_hold got req=%b addr=%h want 1 022", cell_req, cell_addr);
        end
        cell_type = 2'd0; cell_ack = 1'b1;
        tick();
        cell_ack = 1'b0; cell_type = 2'd3;
        checks++;
        if (cell_req !== 1'b0 || busy !== 1'b1 || moved !== 1'b0) begin
            errors++; $display("FAIL open_apply got req=%b busy=%b moved=%b want 0 1 0", cell_req, busy, moved);
        end
        tick();
        checks++;
        if (moved !== 1'b1 || blocked !== 1'b0 || fell !== 1'b0 || busy !== 1'b0 || pos_x !== 5'd2 || pos_y !== 5'd1) begin
            errors++; $display("FAIL open_done got moved=%b blk=%b fell=%b busy=%b pos=(%0d,%0d) want 1 0 0 0 (2,1)",
                               moved, blocked, fell, busy, pos_x, pos_y);
        end
        tick();
        checks++;
        if (moved !== 1'b0) begin
            errors++; $display("FAIL open_pulse_width got moved=%b want 0", moved);
        end
    endtask

    task automatic test_wall();
        do_restart();
        do_move(3, 2'd1, "wall");
        checks++;
        if (blocked !== 1'b1 || moved !== 1'b0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL wall got blk=%b moved=%b pos=(%0d,%0d) want 1 0 (1,1)", blocked, moved, pos_x, pos_y);
        end
        tick();
        checks++;
        if (blocked !== 1'b0) begin
            errors++; $display("FAIL wall_pulse_width got blk=%b want 0", blocked);
        end
    endtask

    task automatic test_edge();
        int nreq = 0;
        int nblk = 0;
        do_restart();
        do_move(1, 2'd0, "edge_pre");
        move_pulses = 4'b0010;
        tick();
        move_pulses = 4'h0;
        for (int i = 0; i < 5; i++) begin
            if (cell_req === 1'b1) nreq++;
            if (blocked === 1'b1) nblk++;
            tick();
        end
        checks++;
        if (nreq !== 0 || nblk !== 1 || pos_x !== 5'd0 || pos_y !== 5'd1) begin
            errors++; $display("FAIL edge got req_cycles=%0d blk_cycles=%0d pos=(%0d,%0d) want 0 1 (0,1)",
                               nreq, nblk, pos_x, pos_y);
        end
    endtask

    task automatic test_hole();
        int nreq = 0;
        do_restart();
        for (int k = 0; k < 4; k++) do_move(0, 2'd0, "hole_walk_x");
        for (int k = 0; k < 4; k++) do_move(2, 2'd0, "hole_walk_y");
        checks++;
        if (pos_x !== 5'd5 || pos_y !== 5'd5) begin
            errors++; $display("FAIL hole_walk got (%0d,%0d) want (5,5)", pos_x, pos_y);
        end
        move_pulses = 4'b0100;
        tick();
        move_pulses = 4'h0;
        wait_req("hole");
        checks++;
        if (cell_addr !== 10'd197) begin
            errors++; $display("FAIL hole_addr got %0d want 197", cell_addr);
        end
        move_pulses = 4'b0001;
        tick();
        move_pulses = 4'h0;
        cell_type = 2'd3; cell_ack = 1'b1;
        tick();
        cell_ack = 1'b0;
        tick();
        checks++;
        if (fell !== 1'b1 || moved !== 1'b0 || blocked !== 1'b0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL hole got fell=%b moved=%b blk=%b pos=(%0d,%0d) want 1 0 0 (1,1)",
                               fell, moved, blocked, pos_x, pos_y);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cell_req === 1'b1) nreq++;
        end
        checks++;
        if (nreq !== 0) begin
            errors++; $display("FAIL hole_pend_cleared got req_cycles=%0d want 0", nreq);
        end
    endtask

    task automatic test_priority();
        logic [9:0] exp_addr [3];
        int nreq = 0;
        exp_addr[0] = 10'h022; exp_addr[1] = 10'h023; exp_addr[2] = 10'h043;
        do_restart();
        move_pulses = 4'b0101;
        tick();
        move_pulses = 4'h0;
        for (int k = 0; k < 3; k++) begin
            wait_req("prio");
            checks++;
            if (cell_addr !== exp_addr[k]) begin
                errors++; $display("FAIL prio_addr%0d got %h want %h", k, cell_addr, exp_addr[k]);
            end
            if (k == 0) begin
                move_pulses = 4'b0001; tick();
                move_pulses = 4'h0;    tick();
                move_pulses = 4'b0001; tick();
                move_pulses = 4'h0;
            end
            cell_type = 2'd0; cell_ack = 1'b1;
            tick();
            cell_ack = 1'b0;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cell_req === 1'b1) nreq++;
        end
        checks++;
        if (nreq !== 0 || pos_x !== 5'd3 || pos_y !== 5'd2) begin
            errors++; $display("FAIL prio_end got extra_req=%0d pos=(%0d,%0d) want 0 (3,2)", nreq, pos_x, pos_y);
        end
    endtask

    task automatic test_restart_mid();
        int bad = 0;
        do_restart();
        move_pulses = 4'b0001;
        tick();
        move_pulses = 4'h0;
        wait_req("rst_mid");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (cell_req !== 1'b0 || busy !== 1'b0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL restart_mid got req=%b busy=%b pos=(%0d,%0d) want 0 0 (1,1)",
                               cell_req, busy, pos_x, pos_y);
        end
        tick();
        cell_type = 2'd0; cell_ack = 1'b1;
        tick();
        cell_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (moved === 1'b1 || cell_req === 1'b1 || busy === 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL restart_late_ack got bad_cycles=%0d pos=(%0d,%0d) want 0 (1,1)", bad, pos_x, pos_y);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        do_restart();
        move_pulses = 4'b0100;
        tick();
        move_pulses = 4'h0;
        wait_req("reset_mid");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (cell_req !== 1'b0 || busy !== 1'b0 || cell_addr !== 10'd0) begin
            errors++; $display("FAIL reset_mid got req=%b busy=%b addr=%h want 0 0 000", cell_req, busy, cell_addr);
        end
        cell_type = 2'd0; cell_ack = 1'b1;
        tick();
        cell_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (moved === 1'b1 || cell_req === 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL reset_late_ack got bad_cycles=%0d pos=(%0d,%0d) want 0 (1,1)", bad, pos_x, pos_y);
        end
    endtask

    task automatic test_goal();
        int bad = 0;
        do_restart();
        do_move(0, 2'd2, "goal");
        checks++;
        if (win !== 1'b1 || moved !== 1'b1 || pos_x !== 5'd2 || pos_y !== 5'd1) begin
            errors++; $display("FAIL goal got win=%b moved=%b pos=(%0d,%0d) want 1 1 (2,1)", win, moved, pos_x, pos_y);
        end
        move_pulses = 4'b0100;
        tick();
        move_pulses = 4'h0;
        for (int i = 0; i < 6; i++) begin
            if (cell_req === 1'b1 || busy === 1'b1 || win !== 1'b1 || pos_x !== 5'd2 || pos_y !== 5'd1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL goal_frozen got bad_cycles=%0d want 0", bad);
        end
        do_restart();
        checks++;
        if (win !== 1'b0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
            errors++; $display("FAIL goal_restart got win=%b pos=(%0d,%0d) want 0 (1,1)", win, pos_x, pos_y);
        end
    endtask

    // Randomized run against a move-by-move model of the ball game
    task automatic test_random();
        int maze [24][32];
        int mx = 1, my = 1, ax = 0, ay = 0, mtype = 0;
        int svc, tx, ty, a, step, r;
        bit mwin = 0, mlook = 0, mapp = 0;
        bit pv [2];
        bit pd [2];
        bit e_mv, e_bl, e_fl, flush, wb, rs, ack, plus, minus;
        logic [3:0] mp;
        logic [1:0] ct;
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 32; x++) begin
                r = int'($urandom_range(0, 99));
                maze[y][x] = (r < 70) ? 0 : (r < 85) ? 1 : (r < 96) ? 3 : 2;
            end
        pv[0] = 0; pv[1] = 0; pd[0] = 0; pd[1] = 0;
        do_restart();
        for (int c = 0; c < 2500; c++) begin
            mp  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            rs  = ($urandom_range(0, 79) == 0);
            ack = mlook ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            ct  = (ack && mlook) ? 2'(maze[ay][ax]) : 2'($urandom_range(0, 3));
            move_pulses = mp; restart = rs; cell_ack = ack; cell_type = ct;

            e_mv = 0; e_bl = 0; e_fl = 0; flush = 0; svc = -1; wb = mwin;
            if (rs) begin
                mx = 1; my = 1; mwin = 0; mlook = 0; mapp = 0; flush = 1;
                pv[0] = 0; pv[1] = 0;
            end else begin
                if (mapp) begin
                    mapp = 0;
                    if (mtype == 0)      begin mx = ax; my = ay; e_mv = 1; end
                    else if (mtype == 1) begin e_bl = 1; end
                    else if (mtype == 2) begin mx = ax; my = ay; e_mv = 1; mwin = 1; end
                    else begin mx = 1; my = 1; e_fl = 1; pv[0] = 0; pv[1] = 0; flush = 1; end
                end else if (mlook) begin
                    if (ack) begin mlook = 0; mapp = 1; mtype = int'(ct); end
                end else if (!wb && (pv[0] || pv[1])) begin
                    a = pv[0] ? 0 : 1;
                    step = pd[a] ? -1 : 1;
                    tx = mx + ((a == 0) ? step : 0);
                    ty = my + ((a == 1) ? step : 0);
                    svc = a;
                    if (tx < 0 || tx > 31 || ty < 0 || ty > 23) e_bl = 1;
                    else begin mlook = 1; ax = tx; ay = ty; end
                end
                if (!flush) begin
                    for (int k = 0; k < 2; k++) begin
                        plus  = mp[2*k];
                        minus = mp[2*k+1];
                        if (!wb && (plus ^ minus)) begin pv[k] = 1; pd[k] = minus; end
                        else if (svc == k) pv[k] = 0;
                    end
                end
            end

            tick();
            checks++;
            if (pos_x !== 5'(mx) || pos_y !== 5'(my)) begin
                errors++; $display("FAIL rand_pos cyc %0d got (%0d,%0d) want (%0d,%0d)", c, pos_x, pos_y, mx, my);
            end
            checks++;
            if ({moved, blocked, fell, win} !== {e_mv, e_bl, e_fl, mwin}) begin
                errors++; $display("FAIL rand_flags cyc %0d got mv/blk/fell/win=%b want %b",
                                   c, {moved, blocked, fell, win}, {e_mv, e_bl, e_fl, mwin});
            end
            checks++;
            if ({cell_req, busy} !== {mlook, mlook | mapp}) begin
                errors++; $display("FAIL rand_req cyc %0d got req/busy=%b want %b", c, {cell_req, busy}, {mlook, mlook | mapp});
            end
            if (mlook) begin
                checks++;
                if (cell_addr !== {5'(ay), 5'(ax)}) begin
                    errors++; $display("FAIL rand_addr cyc %0d got %h want %h", c, cell_addr, {5'(ay), 5'(ax)});
                end
            end
        end
        move_pulses = 4'h0; restart = 1'b0; cell_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; move_pulses = 4'h0; cell_ack = 1'b0; cell_type = 2'd0;
        test_reset();
        test_open_move();
        test_wall();
        test_edge();
        test_hole();
        test_priority();
        test_restart_mid();
        test_reset_mid();
        test_goal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
